// File: rtl/dm_sba_pkg.sv
// Shared types and constants for the debug module System Bus Access block.
package dm_sba_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned DMI_AW = 7;

  localparam logic [DMI_AW-1:0] ADDR_SBCS       = 7'h38;
  localparam logic [DMI_AW-1:0] ADDR_SBADDRESS0 = 7'h39;
  localparam logic [DMI_AW-1:0] ADDR_SBDATA0    = 7'h3C;

  localparam logic [2:0] SBVERSION  = 3'd1;
  localparam logic [2:0] SBACCESS_32 = 3'd2;
  localparam logic [6:0] SBASIZE    = 7'd32;

  typedef enum logic [2:0] {
    SBERR_NONE    = 3'd0,
    SBERR_TIMEOUT = 3'd1,
    SBERR_BADADDR = 3'd2,
    SBERR_ALIGN   = 3'd3,
    SBERR_SIZE    = 3'd4
  } sberror_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } sba_state_e;

  typedef struct packed {
    logic [2:0] sbversion;
    logic [5:0] rsvd;
    logic       sbbusyerror;
    logic       sbbusy;
    logic       sbreadonaddr;
    logic [2:0] sbaccess;
    logic       sbautoincrement;
    logic       sbreadondata;
    logic [2:0] sberror;
    logic [6:0] sbasize;
    logic       sbaccess128;
    logic       sbaccess64;
    logic       sbaccess32;
    logic       sbaccess16;
    logic       sbaccess8;
  } sbcs_t;

endpackage

// File: rtl/dm_sba.sv
// System Bus Access: sbcs/sbaddress0/sbdata0 registers and a single-word
// bus master with error reporting and a busy-cycle timeout.
module dm_sba
  import dm_sba_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmactive,
  input  logic              dmi_req,
  input  logic              dmi_we,
  input  logic [DMI_AW-1:0] dmi_addr,
  input  logic [XLEN-1:0]   dmi_wdata,
  output logic [XLEN-1:0]   dmi_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_ack,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  sba_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  sberror_e        sberror_q, sberror_d;
  logic            busyerr_q, busyerr_d;
  logic            roa_q, roa_d;
  logic            rod_q, rod_d;
  logic            autoinc_q, autoinc_d;
  logic [2:0]      access_q, access_d;
  logic            busy;
  logic            trig_rd;
  logic            trig_wr;
  sbcs_t           sbcs;

  // Next-state: DMI register effects first, then the FSM so bus outcomes win.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    sberror_d = sberror_q;
    busyerr_d = busyerr_q;
    roa_d     = roa_q;
    rod_d     = rod_q;
    autoinc_d = autoinc_q;
    access_d  = access_q;
    trig_rd   = 1'b0;
    trig_wr   = 1'b0;
    busy      = (state_q != ST_IDLE);
    cnt_inc   = cnt_q + CNT_W'(1);

    if (dmi_req) begin
      case (dmi_addr)
        ADDR_SBCS: begin
          if (dmi_we) begin
            if (dmi_wdata[22]) busyerr_d = 1'b0;
            sberror_d = sberror_e'(sberror_q & ~dmi_wdata[14:12]);
            roa_d     = dmi_wdata[20];
            access_d  = dmi_wdata[19:17];
            autoinc_d = dmi_wdata[16];
            rod_d     = dmi_wdata[15];
          end
        end
        ADDR_SBADDRESS0: begin
          if (dmi_we) begin
            if (busy) begin
              busyerr_d = 1'b1;
            end else begin
              addr_d  = dmi_wdata;
              trig_rd = roa_q;
            end
          end
        end
        ADDR_SBDATA0: begin
          if (busy) begin
            busyerr_d = 1'b1;
          end else if (dmi_we) begin
            data_d  = dmi_wdata;
            trig_wr = 1'b1;
          end else begin
            trig_rd = rod_q;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        // Triggers are dropped silently while an error is latched.
        if ((trig_rd || trig_wr) && !busyerr_q && (sberror_q == SBERR_NONE)) begin
          if (access_q != SBACCESS_32) begin
            sberror_d = SBERR_SIZE;
          end else if (addr_d[1:0] != 2'b00) begin
            sberror_d = SBERR_ALIGN;
          end else begin
            state_d = trig_wr ? ST_WRITE : ST_READ;
            cnt_d   = '0;
          end
        end
      end
      ST_READ, ST_WRITE: begin
        if (bus_ack) begin
          state_d = ST_IDLE;
          if (bus_err) begin
            sberror_d = SBERR_BADADDR;
          end else begin
            if (state_q == ST_READ) data_d = bus_rdata;
            if (autoinc_q) addr_d = addr_q + XLEN'(4);
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            state_d   = ST_IDLE;
            sberror_d = SBERR_TIMEOUT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      sberror_q <= SBERR_NONE;
      busyerr_q <= 1'b0;
      roa_q     <= 1'b0;
      rod_q     <= 1'b0;
      autoinc_q <= 1'b0;
      access_q  <= SBACCESS_32;
    end else if (!dmactive) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      sberror_q <= SBERR_NONE;
      busyerr_q <= 1'b0;
      roa_q     <= 1'b0;
      rod_q     <= 1'b0;
      autoinc_q <= 1'b0;
      access_q  <= SBACCESS_32;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      sberror_q <= sberror_d;
      busyerr_q <= busyerr_d;
      roa_q     <= roa_d;
      rod_q     <= rod_d;
      autoinc_q <= autoinc_d;
      access_q  <= access_d;
    end
  end

  // Register read-back mux.
  always_comb begin
    sbcs                 = '0;
    sbcs.sbversion       = SBVERSION;
    sbcs.sbbusyerror     = busyerr_q;
    sbcs.sbbusy          = (state_q != ST_IDLE);
    sbcs.sbreadonaddr    = roa_q;
    sbcs.sbaccess        = access_q;
    sbcs.sbautoincrement = autoinc_q;
    sbcs.sbreadondata    = rod_q;
    sbcs.sberror         = sberror_q;
    sbcs.sbasize         = SBASIZE;
    sbcs.sbaccess32      = 1'b1;
    case (dmi_addr)
      ADDR_SBCS:       dmi_rdata = sbcs;
      ADDR_SBADDRESS0: dmi_rdata = addr_q;
      ADDR_SBDATA0:    dmi_rdata = data_q;
      default:         dmi_rdata = '0;
    endcase
  end

  assign bus_req   = (state_q != ST_IDLE);
  assign bus_we    = (state_q == ST_WRITE);
  assign bus_addr  = addr_q;
  assign bus_wdata = data_q;

endmodule

// File: tb/tb_dm_sba.sv
// Directed and randomized bench for dm_sba against a transaction-level model
// of the SBA register set.
module tb_dm_sba;
  import dm_sba_pkg::*;

  localparam int unsigned TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmactive;
  logic        dmi_req;
  logic        dmi_we;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  dm_sba #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .dmactive(dmactive),
    .dmi_req(dmi_req), .dmi_we(dmi_we), .dmi_addr(dmi_addr),
    .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural view of the registers.
  logic [31:0] m_addr;
  logic [31:0] m_data;
  int unsigned m_err;
  int unsigned m_access;
  bit          m_busyerr, m_roa, m_rod, m_autoinc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_addr = 0; m_data = 0; m_err = 0; m_access = 2;
    m_busyerr = 0; m_roa = 0; m_rod = 0; m_autoinc = 0;
  endfunction

  function automatic logic [31:0] exp_sbcs(input bit busy);
    return (32'd1 << 29) | (32'(m_busyerr) << 22) | (32'(busy) << 21) |
           (32'(m_roa) << 20) | (32'(m_access) << 17) | (32'(m_autoinc) << 16) |
           (32'(m_rod) << 15) | (32'(m_err) << 12) | (32'd32 << 5) | 32'd4;
  endfunction

  // Decide whether a trigger starts a bus access, latching any error it causes.
  function automatic bit start_ok();
    if (m_busyerr || m_err != 0) return 0;
    if (m_access != 2) begin m_err = 4; return 0; end
    if (m_addr % 4 != 0) begin m_err = 3; return 0; end
    return 1;
  endfunction

  task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    dmi_req = 1; dmi_we = 1; dmi_addr = a; dmi_wdata = d;
    @(negedge clk);
    dmi_req = 0; dmi_we = 0;
  endtask

  task automatic dmi_rd(input logic [6:0] a, output logic [31:0] d);
    @(negedge clk);
    dmi_req = 1; dmi_we = 0; dmi_addr = a;
    #1 d = dmi_rdata;
    @(negedge clk);
    dmi_req = 0;
  endtask

  // Bus slave: entered on the negedge after the triggering request.
  task automatic serve(input bit we, input int delay, input logic [31:0] rd,
                       input bit err, input bit noack);
    bit stable = 1;
    logic [31:0] a0 = m_addr;
    chk("bus_req_start", bus_req, 1);
    chk("bus_we", bus_we, we);
    chk("bus_addr", bus_addr, m_addr);
    if (we) chk("bus_wdata", bus_wdata, m_data);
    if (noack) begin
      repeat (TO - 1) begin
        @(negedge clk);
        if (bus_req !== 1'b1 || bus_addr !== a0) stable = 0;
      end
      chk("hold_until_timeout", 32'(stable), 1);
      @(negedge clk);
      chk("bus_req_timeout_drop", bus_req, 0);
      m_err = 1;
    end else begin
      repeat (delay) begin
        @(negedge clk);
        if (bus_req !== 1'b1 || bus_addr !== a0) stable = 0;
      end
      bus_ack = 1; bus_rdata = rd; bus_err = err;
      @(negedge clk);
      bus_ack = 0; bus_err = 0;
      chk("hold_until_ack", 32'(stable), 1);
      chk("bus_req_done", bus_req, 0);
      if (err) m_err = 2;
      else begin
        if (!we) m_data = rd;
        if (m_autoinc) m_addr = m_addr + 32'd4;
      end
    end
  endtask

  task automatic wr_sbcs(input bit roa, input int unsigned acc, input bit ai,
                         input bit rod, input bit clrbe, input int unsigned w1c);
    dmi_wr(ADDR_SBCS, (32'(clrbe) << 22) | (32'(roa) << 20) | (32'(acc & 7) << 17) |
                      (32'(ai) << 16) | (32'(rod) << 15) | (32'(w1c & 7) << 12));
    if (clrbe) m_busyerr = 0;
    m_err = m_err & ~(w1c & 7);
    m_roa = roa; m_access = acc & 7; m_autoinc = ai; m_rod = rod;
  endtask

  task automatic wr_addr(input logic [31:0] d, input int dl, input logic [31:0] rd,
                         input bit err, input bit noack);
    dmi_wr(ADDR_SBADDRESS0, d);
    m_addr = d;
    if (m_roa && start_ok()) serve(0, dl, rd, err, noack);
    else chk("no_bus_req_addr", bus_req, 0);
  endtask

  task automatic wr_data(input logic [31:0] d, input int dl, input bit err);
    dmi_wr(ADDR_SBDATA0, d);
    m_data = d;
    if (start_ok()) serve(1, dl, 0, err, 0);
    else chk("no_bus_req_data", bus_req, 0);
  endtask

  task automatic rd_data(input int dl, input logic [31:0] rd, input bit err);
    logic [31:0] got;
    dmi_rd(ADDR_SBDATA0, got);
    chk("sbdata0_read", got, m_data);
    if (m_rod && start_ok()) serve(0, dl, rd, err, 0);
    else chk("no_bus_req_rd", bus_req, 0);
  endtask

  task automatic chk_regs(input string tag);
    logic [31:0] got;
    dmi_rd(ADDR_SBCS, got);
    chk({tag, "_sbcs"}, got, exp_sbcs(0));
    dmi_rd(ADDR_SBADDRESS0, got);
    chk({tag, "_sbaddress0"}, got, m_addr);
  endtask

  initial begin
    logic [31:0] got, r;
    rst = 1; dmactive = 1; dmi_req = 0; dmi_we = 0; dmi_addr = ADDR_SBCS;
    dmi_wdata = 0; bus_ack = 0; bus_rdata = 0; bus_err = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    #1 chk("rst_sbcs", dmi_rdata, exp_sbcs(0));
    dmi_addr = 7'h10;
    #1 chk("unmapped_read", dmi_rdata, 0);
    @(negedge clk); rst = 0;

    // Read on address write.
    wr_sbcs(1, 2, 0, 0, 0, 0);
    wr_addr(32'h1000, 3, 32'hDEADBEEF, 0, 0);
    rd_data(0, 0, 0);
    chk("read_result", m_data, 32'hDEADBEEF);
    chk_regs("after_read");

    // Autoincrementing writes.
    wr_sbcs(0, 2, 1, 0, 0, 0);
    wr_addr(32'h2000, 0, 0, 0, 0);
    wr_data(32'h11, 0, 0);
    wr_data(32'h22, 0, 0);
    dmi_rd(ADDR_SBADDRESS0, got);
    chk("autoinc_end", got, 32'h2008);
    chk_regs("after_autoinc");

    // Busy error while a write is pending, plus DMI coincident with ack.
    wr_sbcs(0, 2, 0, 0, 0, 0);
    wr_addr(32'h3000, 0, 0, 0, 0);
    dmi_wr(ADDR_SBDATA0, 32'h55);
    m_data = 32'h55;
    chk("busy_write_req", bus_req, 1);
    dmi_wr(ADDR_SBDATA0, 32'hAA);
    m_busyerr = 1;
    dmi_rd(ADDR_SBCS, got);
    chk("busy_sbcs", got, exp_sbcs(1));
    chk("busy_wdata_stable", bus_wdata, 32'h55);
    @(negedge clk);
    bus_ack = 1; dmi_req = 1; dmi_we = 0; dmi_addr = ADDR_SBDATA0;
    #1 chk("ack_cycle_stale_read", dmi_rdata, 32'h55);
    @(negedge clk);
    bus_ack = 0; dmi_req = 0;
    chk("busy_write_done", bus_req, 0);
    chk_regs("busyerr_set");
    rd_data(0, 0, 0);
    wr_data(32'h77, 0, 0);
    wr_sbcs(0, 2, 0, 0, 1, 0);
    wr_data(32'h88, 1, 0);
    chk_regs("busyerr_cleared");

    // Alignment and size errors.
    wr_sbcs(1, 2, 0, 0, 0, 0);
    wr_addr(32'h1002, 0, 0, 0, 0);
    chk_regs("align_err");
    wr_sbcs(1, 1, 0, 0, 0, 7);
    wr_addr(32'h1002, 0, 0, 0, 0);
    chk_regs("size_err");

    // Timeout, bus error, and ack on the timeout cycle.
    wr_sbcs(1, 2, 0, 0, 0, 7);
    wr_addr(32'h4000, 0, 0, 0, 1);
    chk_regs("timeout_err");
    wr_sbcs(1, 2, 0, 0, 0, 7);
    wr_addr(32'h4000, 0, 0, 1, 0);
    chk_regs("bus_err");
    wr_sbcs(1, 2, 0, 0, 0, 7);
    wr_addr(32'h4004, TO - 1, 32'hCAFEF00D, 0, 0);
    chk_regs("ack_vs_timeout");
    rd_data(0, 0, 0);

    // dmactive low clears state and ignores DMI.
    wr_sbcs(1, 2, 1, 1, 0, 0);
    @(negedge clk);
    dmactive = 0; dmi_req = 1; dmi_we = 1; dmi_addr = ADDR_SBDATA0; dmi_wdata = 32'h1234;
    @(negedge clk);
    dmi_req = 0; dmi_we = 0; dmactive = 1;
    chk("dmactive_no_req", bus_req, 0);
    model_reset();
    chk_regs("dmactive_clear");
    rd_data(0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int op = $urandom_range(0, 3);
      int dl = $urandom_range(0, 6);
      bit be = ($urandom_range(0, 7) == 0);
      r = $urandom;
      case (op)
        0: wr_addr((r & ~32'h3) | (($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'd0),
                   dl, $urandom, be, 0);
        1: wr_data(r, dl, be);
        2: rd_data(dl, r, be);
        default: wr_sbcs(1'($urandom_range(0, 1)),
                         ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4) : 2,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), $urandom_range(0, 7));
      endcase
      chk_regs("rand");
    end

    // Asynchronous reset in the middle of a read.
    wr_sbcs(1, 2, 0, 0, 1, 7);
    dmi_wr(ADDR_SBADDRESS0, 32'h5000);
    chk("pre_reset_req", bus_req, 1);
    #2 rst = 1;
    #1 chk("async_rst_req", bus_req, 0);
    chk("async_rst_addr", bus_addr, 0);
    model_reset();
    dmi_addr = ADDR_SBCS;
    #1 chk("rst_mid_sbcs", dmi_rdata, exp_sbcs(0));
    dmi_addr = ADDR_SBADDRESS0;
    #1 chk("rst_mid_addr", dmi_rdata, 0);
    dmi_addr = ADDR_SBDATA0;
    #1 chk("rst_mid_data", dmi_rdata, 0);
    @(negedge clk);
    rst = 0;
    chk_regs("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
